if_bundle_fetch: RTL
====================

// Module: if_bundle_fetch
// PURPOSE
// - Instruction-fetch stage of the 4-slot VLIW CPU; directly upstream of instruction decode.
// - Holds the PC and reads one 88-bit bundle per cycle from synchronous instruction memory.
// - Splits the bundle into the A0/A1/M/LS 22-bit slots consumed by decode.
// - Handles decode stalls with a 1-entry skid buffer and jump redirects with a pipeline flush.
// PARAMETERS
// - PC_W     16      PC / imem address width (word-addressed, one bundle per word)
// - INSTR_W  22      width of one slot instruction
// - RESET_PC 16'h0   first bundle address after reset
// PORTS
// - clk          in   1          system clock, all state on rising edge
// - rst          in   1          asynchronous, active-high reset
// - imem_addr    out  PC_W       bundle address; combinational: redirect ? redirect_pc : pc
// - imem_rd_en   out  1          read strobe; data returns on imem_data the following cycle
// - imem_data    in   4*INSTR_W  {A0[87:66], A1[65:44], M[43:22], LS[21:0]}
// - stall        in   1          decode/hazard stall: hold presented bundle
// - redirect     in   1          taken jump (decode predRW path): flush and refetch
// - redirect_pc  in   PC_W       jump target
// - A0, A1, M, LS out INSTR_W   registered slot instructions to decode
// - if_pc        out  PC_W       address of the bundle currently presented
// - if_valid     out  1          presented bundle is real (0 = NOP bubble)
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=BOOT, imem_rd_en=0, A0/A1/M/LS=NOP (22'h0), if_pc=0, if_valid=0, skid empty, in-flight flag clear.
// - Latency: address issued cycle N; imem_data valid N+1; registered to outputs visible N+2.
// - FSM BOOT: rd_en=1 with imem_addr=pc, pc<=pc+1, in-flight<=1 -> RUN. Outputs stay NOP.
// - FSM RUN, stall=0: issue pc, pc<=pc+1; if in-flight, outputs<=imem_data, if_pc<=pc of that fetch, if_valid<=1.
// - FSM RUN, stall=1: outputs hold; rd_en=0, pc holds; arriving in-flight data -> skid -> HOLD.
// - FSM HOLD, stall=1: everything holds; rd_en=0; skid never overwritten (only one fetch can be outstanding).
// - FSM HOLD, stall=0: outputs<=skid if valid (else hold NOP), skid cleared, issue pc, pc<=pc+1 -> RUN.
// - Redirect (any state, priority over stall): imem_addr=redirect_pc, rd_en=1, pc<=redirect_pc+1.
//   Outputs<=NOP, if_valid<=0, skid cleared, previous in-flight data discarded. Next state RUN.
//   If stall is also high, the redirect fetch still issues; its data lands in skid (state HOLD).
// - Back-to-back redirects: each cancels the prior; only the last target's bundle is presented.
// - PC arithmetic: pc+1 wraps modulo 2^PC_W (16'hFFFF -> 16'h0000), no error flag.
// - if_valid=0 means all four slots are NOP; decode needs no extra qualification.
// - Reset asserted mid-operation: immediate return to reset values, in-flight read ignored.
// STRUCTURE
// - Shared package cpu_pkg: INSTR_W, PC_W, NOP_INSTR=22'h0, OP_JMP=5'b01001,
//   slot field ranges (op[4:0], R0[9:5], R1/imm[14:10], Rd/R2[19:15], cond[21:20]), bundle slot order.
// - FSM state enum (BOOT, RUN, HOLD) local to this module.
// - One sub-module: if_skid_buf (1-entry, 4*INSTR_W+PC_W data + valid, load/clear/pop).
// - Expected size ~180-250 lines RTL.
// TESTING
// - Reset release, imem word k = {4{k[21:0]}}: first valid bundle at cycle 3 with if_pc=0, then pc 1,2,3 each cycle.
// - Stall high 3 cycles while streaming at pc 5: outputs hold bundle 5; bundle 6 held in skid; after release 6,7 follow, none lost/duplicated.
// - Redirect to 16'h0040 while presenting pc 9: next cycle if_valid=0/NOP, then bundle 0x40, 0x41; bundle 10 never shown.
// - Redirect and stall together, stall held 2 more cycles: outputs NOP/if_valid=0 throughout; on release bundle redirect target appears.
// - PC wrap: RESET_PC=16'hFFFE: bundles FFFE, FFFF, 0000, 0001 in order.
// - Assert rst mid-stall with skid full: outputs NOP and if_valid=0 asynchronously; refetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-slot VLIW CPU front end: widths, NOP encoding, slot fields.
// No logic here; pure constants and types.
// Slot order inside a bundle, MSB first: A0, A1, M, LS.
package cpu_pkg;

    localparam int INSTR_W  = 22;
    localparam int PC_W     = 16;
    localparam int SLOTS    = 4;
    localparam int BUNDLE_W = SLOTS * INSTR_W;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 22'h0;
    localparam logic [4:0]         OP_JMP    = 5'b01001;

    // Field ranges inside one slot instruction
    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 4;
    localparam int R0_LSB   = 5;
    localparam int R0_MSB   = 9;
    localparam int R1_LSB   = 10;   // R1 or immediate
    localparam int R1_MSB   = 14;
    localparam int RD_LSB   = 15;   // Rd or R2
    localparam int RD_MSB   = 19;
    localparam int COND_LSB = 20;
    localparam int COND_MSB = 21;

    // Slot index within a bundle; index 0 occupies the most significant bits
    localparam int SLOT_A0 = 0;
    localparam int SLOT_A1 = 1;
    localparam int SLOT_M  = 2;
    localparam int SLOT_LS = 3;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        instr_t a0;
        instr_t a1;
        instr_t m;
        instr_t ls;
    } bundle_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched bundle plus its PC while decode is stalled.
// Latency: load visible the cycle after; clear/pop empty it the cycle after.
// Backpressure: a load while already full is ignored, so the held entry is never overwritten.
module if_skid_buf #(
    parameter int DAT_W = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             pop_i,
    input  logic [DAT_W-1:0] dat_i,
    output logic             vld_o,
    output logic [DAT_W-1:0] dat_o
);

    logic             vld_q;
    logic             vld_d;
    logic [DAT_W-1:0] dat_q;
    logic [DAT_W-1:0] dat_d;

    // Next-state: flush/pop empty the entry; a load only fills an empty entry
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clear_i || pop_i) begin
            vld_d = 1'b0;
        end else if (load_i && !vld_q) begin
            vld_d = 1'b1;
            dat_d = dat_i;
        end
    end

    // Entry storage with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/if_bundle_fetch.sv
// Instruction fetch: holds the PC, reads one bundle per cycle, presents A0/A1/M/LS to decode.
// Latency: address cycle N, imem data N+1, registered slots visible N+2.
// Backpressure: stall freezes outputs and PC; one in-flight bundle parks in a skid entry.
module if_bundle_fetch #(
    parameter int                 PC_W     = cpu_pkg::PC_W,
    parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PC_W-1:0]      imem_addr,
    output logic                 imem_rd_en,
    input  logic [4*INSTR_W-1:0] imem_data,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic [INSTR_W-1:0]   A0,
    output logic [INSTR_W-1:0]   A1,
    output logic [INSTR_W-1:0]   M,
    output logic [INSTR_W-1:0]   LS,
    output logic [PC_W-1:0]      if_pc,
    output logic                 if_valid
);

    import cpu_pkg::*;

    localparam int BW    = 4 * INSTR_W;
    localparam int SKD_W = BW + PC_W;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            infl_q, infl_d;          // a read issued last cycle returns now
    logic [PC_W-1:0] infl_pc_q, infl_pc_d;    // address of that read
    logic [BW-1:0]   bundle_q, bundle_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic            if_valid_q, if_valid_d;

    logic            rd_en_c;
    logic [PC_W-1:0] addr_c;
    logic            skid_load;
    logic            skid_clear;
    logic            skid_pop;
    logic            skid_vld;
    logic [SKD_W-1:0] skid_dat;

    if_skid_buf #(
        .DAT_W (SKD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pop_i   (skid_pop),
        .dat_i   ({imem_data, infl_pc_q}),
        .vld_o   (skid_vld),
        .dat_o   (skid_dat)
    );

    // Next-state and fetch control; redirect overrides every state and the stall
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        infl_d     = 1'b0;
        infl_pc_d  = infl_pc_q;
        bundle_d   = bundle_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        rd_en_c    = 1'b0;
        addr_c     = pc_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        skid_pop   = 1'b0;

        if (redirect) begin
            // Drop whatever is presented, parked or in flight; fetch the target now.
            // If decode is also stalled, the target's data parks in the skid next cycle.
            addr_c     = redirect_pc;
            rd_en_c    = 1'b1;
            pc_d       = redirect_pc + 1'b1;
            infl_d     = 1'b1;
            infl_pc_d  = redirect_pc;
            bundle_d   = {4{NOP_INSTR}};
            if_valid_d = 1'b0;
            skid_clear = 1'b1;
            state_d    = RUN;
        end else begin
            unique case (state_q)
                BOOT: begin
                    rd_en_c   = 1'b1;
                    pc_d      = pc_q + 1'b1;
                    infl_d    = 1'b1;
                    infl_pc_d = pc_q;
                    state_d   = RUN;
                end
                RUN: begin
                    if (!stall) begin
                        rd_en_c   = 1'b1;
                        pc_d      = pc_q + 1'b1;
                        infl_d    = 1'b1;
                        infl_pc_d = pc_q;
                        if (infl_q) begin
                            bundle_d   = imem_data;
                            if_pc_d    = infl_pc_q;
                            if_valid_d = 1'b1;
                        end
                    end else if (infl_q) begin
                        // Read cannot be cancelled at the memory, so park its data
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (skid_vld) begin
                            bundle_d   = skid_dat[SKD_W-1 -: BW];
                            if_pc_d    = skid_dat[PC_W-1:0];
                            if_valid_d = 1'b1;
                        end
                        skid_pop  = 1'b1;
                        rd_en_c   = 1'b1;
                        pc_d      = pc_q + 1'b1;
                        infl_d    = 1'b1;
                        infl_pc_d = pc_q;
                        state_d   = RUN;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // Pipeline state with asynchronous reset back to the boot condition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            bundle_q   <= {4{NOP_INSTR}};
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            infl_q     <= infl_d;
            infl_pc_q  <= infl_pc_d;
            bundle_q   <= bundle_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    // The read strobe is masked while reset is held so memory sees no access
    assign imem_rd_en = rd_en_c & ~rst;
    assign imem_addr  = addr_c;

    assign A0       = bundle_q[4*INSTR_W-1 -: INSTR_W];
    assign A1       = bundle_q[3*INSTR_W-1 -: INSTR_W];
    assign M        = bundle_q[2*INSTR_W-1 -: INSTR_W];
    assign LS       = bundle_q[INSTR_W-1:0];
    assign if_pc    = if_pc_q;
    assign if_valid = if_valid_q;

endmodule
